// File: rtl/vending_pkg.sv
// vending_pkg: shared types and constants
// for the coin-operated vending controller.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    VEND,
    CHANGE
  } state_t;

  typedef logic [1:0] coin_t;

  localparam coin_t COIN_NONE = 2'b00;
  localparam coin_t COIN_N    = 2'b01;
  localparam coin_t COIN_D    = 2'b10;
  localparam coin_t COIN_Q    = 2'b11;

  localparam int VAL_N = 5;
  localparam int VAL_D = 10;
  localparam int VAL_Q = 25;

  function automatic int coin_value(
    input coin_t c
  );
    case (c)
      COIN_N:  return VAL_N;
      COIN_D:  return VAL_D;
      COIN_Q:  return VAL_Q;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/vend_change_sel.sv
// vend_change_sel: greedy change picker,
// largest coin not exceeding the credit.
module vend_change_sel
  import vending_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] i_credit,
  output coin_t        o_coin,
  output logic [W-1:0] o_value
);

  // pick quarter, then dime, else nickel
  always_comb begin
    o_coin  = COIN_N;
    o_value = W'(VAL_N);
    if (i_credit >= W'(VAL_Q)) begin
      o_coin  = COIN_Q;
      o_value = W'(VAL_Q);
    end else if (i_credit >= W'(VAL_D)) begin
      o_coin  = COIN_D;
      o_value = W'(VAL_D);
    end
  end

endmodule

// File: rtl/vending_ctrl.sv
// vending_ctrl: credit accumulation, vend
// strobe and greedy change/refund dispense.
module vending_ctrl
  import vending_pkg::*;
#(
  parameter int PRICE    = 30,
  parameter int CREDIT_W = 8
) (
  input  logic                clk,
  input  logic                r,
  input  logic                coin_valid,
  input  logic [1:0]          coin_sel,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                vend,
  output logic                chg_valid,
  output logic [1:0]          chg_coin,
  output logic                coin_reject,
  output logic                busy
);

  if ((PRICE % 5) != 0 || PRICE < 5 ||
      PRICE > 235) begin : g_bad_price
    $error("vending_ctrl: bad PRICE");
  end

  if (CREDIT_W < 9 &&
      (1 << CREDIT_W) <= PRICE + 20)
  begin : g_bad_width
    $error("vending_ctrl: CREDIT_W small");
  end

  localparam logic [CREDIT_W-1:0] W_PRICE =
    CREDIT_W'(PRICE);

  state_t              r_state;
  state_t              w_next;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] w_credit_nxt;
  logic                r_reject;
  logic                w_reject_nxt;
  logic                w_coin_ok;
  logic [CREDIT_W-1:0] w_coin_val;
  logic [CREDIT_W-1:0] w_sum;
  coin_t               w_chg_coin;
  logic [CREDIT_W-1:0] w_chg_val;

  assign w_coin_ok  = coin_valid &&
                      (coin_sel != COIN_NONE);
  assign w_coin_val = CREDIT_W'(
                        coin_value(coin_sel));
  assign w_sum      = r_credit + w_coin_val;

  vend_change_sel #(
    .W (CREDIT_W)
  ) u_sel (
    .i_credit (r_credit),
    .o_coin   (w_chg_coin),
    .o_value  (w_chg_val)
  );

  // state, credit and reject strobe flops
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      r_state  <= IDLE;
      r_credit <= '0;
      r_reject <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_credit <= w_credit_nxt;
      r_reject <= w_reject_nxt;
    end
  end

  // next state; cancel outranks a coin
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, ACCUM: begin
        if (cancel) begin
          if (r_state == ACCUM)
            w_next = CHANGE;
        end else if (w_coin_ok) begin
          w_next = (w_sum >= W_PRICE) ?
                   VEND : ACCUM;
        end
      end
      VEND:
        w_next = (r_credit == W_PRICE) ?
                 IDLE : CHANGE;
      CHANGE:
        w_next = (r_credit == w_chg_val) ?
                 IDLE : CHANGE;
      default: w_next = IDLE;
    endcase
  end

  // next credit; any unaccepted coin bounces
  always_comb begin
    w_credit_nxt = r_credit;
    w_reject_nxt = coin_valid;
    unique case (r_state)
      IDLE, ACCUM: begin
        if (!cancel && w_coin_ok) begin
          w_credit_nxt = w_sum;
          w_reject_nxt = 1'b0;
        end
      end
      VEND:
        w_credit_nxt = r_credit - W_PRICE;
      CHANGE:
        w_credit_nxt = r_credit - w_chg_val;
      default: w_credit_nxt = '0;
    endcase
  end

  // outputs decoded from the flops
  always_comb begin
    credit      = r_credit;
    coin_reject = r_reject;
    vend        = (r_state == VEND);
    chg_valid   = (r_state == CHANGE);
    chg_coin    = (r_state == CHANGE) ?
                  w_chg_coin : COIN_NONE;
    busy        = (r_state == VEND) ||
                  (r_state == CHANGE);
  end

endmodule

// File: tb/tb_vending_ctrl.sv
// tb_vending_ctrl: two controllers (price 30
// and 235) on shared stimulus vs a model.
module tb_vending_ctrl;

  localparam logic [1:0] CX = 2'b00;
  localparam logic [1:0] CN = 2'b01;
  localparam logic [1:0] CD = 2'b10;
  localparam logic [1:0] CQ = 2'b11;

  logic       clk = 1'b0;
  logic       r;
  logic       cv;
  logic [1:0] cs;
  logic       cn;

  logic [7:0] o_cr   [2];
  logic       o_vd   [2];
  logic       o_cvld [2];
  logic [1:0] o_cc   [2];
  logic       o_rej  [2];
  logic       o_busy [2];

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int         cr;
    bit         vd;
    logic [1:0] coin;
  } exp_t;

  int   price [2];
  exp_t q     [2][$];
  int   mc    [2];
  bit   rej   [2];

  always #5 clk = ~clk;

  vending_ctrl #(
    .PRICE    (30),
    .CREDIT_W (8)
  ) u0 (
    .clk         (clk),
    .r           (r),
    .coin_valid  (cv),
    .coin_sel    (cs),
    .cancel      (cn),
    .credit      (o_cr[0]),
    .vend        (o_vd[0]),
    .chg_valid   (o_cvld[0]),
    .chg_coin    (o_cc[0]),
    .coin_reject (o_rej[0]),
    .busy        (o_busy[0])
  );

  vending_ctrl #(
    .PRICE    (235),
    .CREDIT_W (8)
  ) u1 (
    .clk         (clk),
    .r           (r),
    .coin_valid  (cv),
    .coin_sel    (cs),
    .cancel      (cn),
    .credit      (o_cr[1]),
    .vend        (o_vd[1]),
    .chg_valid   (o_cvld[1]),
    .chg_coin    (o_cc[1]),
    .coin_reject (o_rej[1]),
    .busy        (o_busy[1])
  );

  task automatic chk(string nm, int act,
                     int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, expv);
    end
  endtask

  function automatic int cval(
    input logic [1:0] s
  );
    case (s)
      CN:      return 5;
      CD:      return 10;
      CQ:      return 25;
      default: return 0;
    endcase
  endfunction

  // queue the cycles of a greedy payout
  task automatic push_change(int k, int amt);
    int rem;
    rem = amt;
    while (rem > 0) begin
      if (rem >= 25) begin
        q[k].push_back('{rem, 1'b0, CQ});
        rem -= 25;
      end else if (rem >= 10) begin
        q[k].push_back('{rem, 1'b0, CD});
        rem -= 10;
      end else begin
        q[k].push_back('{rem, 1'b0, CN});
        rem -= 5;
      end
    end
  endtask

  // one clock edge of the model
  task automatic model_step(int k);
    int   s;
    exp_t e;
    rej[k] = 1'b0;
    if (q[k].size() > 0) begin
      e = q[k].pop_front();
      if (cv) rej[k] = 1'b1;
      if (q[k].size() == 0) mc[k] = 0;
    end else if (cn) begin
      if (cv) rej[k] = 1'b1;
      if (mc[k] > 0) push_change(k, mc[k]);
    end else if (cv) begin
      if (cs == CX) begin
        rej[k] = 1'b1;
      end else begin
        s = mc[k] + cval(cs);
        if (s >= price[k]) begin
          q[k].push_back('{s, 1'b1, CX});
          push_change(k, s - price[k]);
        end else begin
          mc[k] = s;
        end
      end
    end
  endtask

  // model update and per-cycle compare
  always begin
    int         ecr;
    bit         evd;
    bit         ebz;
    logic [1:0] ecc;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!r) begin
        q[k].delete();
        mc[k]  = 0;
        rej[k] = 1'b0;
      end else begin
        model_step(k);
      end
    end
    #1;
    if (r) begin
      for (int k = 0; k < 2; k++) begin
        if (q[k].size() > 0) begin
          ecr = q[k][0].cr;
          evd = q[k][0].vd;
          ecc = q[k][0].coin;
          ebz = 1'b1;
        end else begin
          ecr = mc[k];
          evd = 1'b0;
          ecc = CX;
          ebz = 1'b0;
        end
        chk($sformatf("d%0d credit", k),
            int'(o_cr[k]), ecr);
        chk($sformatf("d%0d vend", k),
            int'(o_vd[k]), int'(evd));
        chk($sformatf("d%0d chg_valid", k),
            int'(o_cvld[k]),
            int'(ecc != CX));
        chk($sformatf("d%0d chg_coin", k),
            int'(o_cc[k]), int'(ecc));
        chk($sformatf("d%0d reject", k),
            int'(o_rej[k]), int'(rej[k]));
        chk($sformatf("d%0d busy", k),
            int'(o_busy[k]), int'(ebz));
      end
    end
  end

  task automatic step(logic v,
                      logic [1:0] s,
                      logic c);
    cv = v;
    cs = s;
    cn = c;
    @(posedge clk);
    #1;
  endtask

  task automatic rst();
    cv = 1'b0;
    cs = CX;
    cn = 1'b0;
    r  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    r = 1'b1;
  endtask

  task automatic rst_lits(int k);
    chk("rst credit", int'(o_cr[k]), 0);
    chk("rst vend", int'(o_vd[k]), 0);
    chk("rst chg_valid", int'(o_cvld[k]), 0);
    chk("rst chg_coin", int'(o_cc[k]), 0);
    chk("rst reject", int'(o_rej[k]), 0);
    chk("rst busy", int'(o_busy[k]), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    price[0] = 30;
    price[1] = 235;
    r  = 1'b1;
    cv = 1'b0;
    cs = CX;
    cn = 1'b0;
    #2 r = 1'b0;
    #1;
    rst_lits(0);
    rst_lits(1);
    @(posedge clk);
    @(posedge clk);
    #1 r = 1'b1;

    // quarter + dime -> nickel change
    step(1, CQ, 0);
    chk("t1 credit25", int'(o_cr[0]), 25);
    step(1, CD, 0);
    chk("t1 credit35", int'(o_cr[0]), 35);
    chk("t1 vend", int'(o_vd[0]), 1);
    step(0, CX, 0);
    chk("t1 vend off", int'(o_vd[0]), 0);
    chk("t1 coin N", int'(o_cc[0]), 1);
    chk("t1 credit5", int'(o_cr[0]), 5);
    step(0, CX, 0);
    chk("t1 credit0", int'(o_cr[0]), 0);
    chk("t1 idle", int'(o_busy[0]), 0);

    // quarter + quarter -> dime, dime
    rst();
    step(1, CQ, 0);
    step(1, CQ, 0);
    chk("t2 credit50", int'(o_cr[0]), 50);
    step(0, CX, 0);
    chk("t2 coin D1", int'(o_cc[0]), 2);
    chk("t2 credit20", int'(o_cr[0]), 20);
    step(0, CX, 0);
    chk("t2 coin D2", int'(o_cc[0]), 2);
    chk("t2 credit10", int'(o_cr[0]), 10);
    step(0, CX, 0);
    chk("t2 credit0", int'(o_cr[0]), 0);
    chk("t2 chg off", int'(o_cvld[0]), 0);

    // dime, dime, cancel -> refund
    rst();
    step(1, CD, 0);
    step(1, CD, 0);
    chk("t3 credit20", int'(o_cr[0]), 20);
    step(0, CX, 1);
    chk("t3 no vend", int'(o_vd[0]), 0);
    chk("t3 coin D1", int'(o_cc[0]), 2);
    step(0, CX, 0);
    chk("t3 credit10", int'(o_cr[0]), 10);
    step(0, CX, 0);
    chk("t3 credit0", int'(o_cr[0]), 0);

    // rejects: invalid, in VEND, in CHANGE
    rst();
    step(1, CX, 0);
    chk("t4 rej idle", int'(o_rej[0]), 1);
    chk("t4 credit0", int'(o_cr[0]), 0);
    step(1, CQ, 0);
    chk("t4 rej off", int'(o_rej[0]), 0);
    step(1, CQ, 0);
    chk("t4 vend", int'(o_vd[0]), 1);
    step(1, CQ, 0);
    chk("t4 rej vend", int'(o_rej[0]), 1);
    chk("t4 credit20", int'(o_cr[0]), 20);
    step(1, CD, 0);
    chk("t4 rej chg", int'(o_rej[0]), 1);
    chk("t4 credit10", int'(o_cr[0]), 10);
    step(0, CX, 0);
    chk("t4 rej end", int'(o_rej[0]), 0);
    chk("t4 credit0", int'(o_cr[0]), 0);

    // cancel + quarter at credit 10
    rst();
    step(1, CD, 0);
    step(1, CQ, 1);
    chk("t5 reject", int'(o_rej[0]), 1);
    chk("t5 coin D", int'(o_cc[0]), 2);
    chk("t5 credit10", int'(o_cr[0]), 10);
    step(0, CX, 0);
    chk("t5 credit0", int'(o_cr[0]), 0);

    // reset while dispensing
    rst();
    step(1, CQ, 0);
    step(1, CQ, 0);
    step(0, CX, 0);
    step(0, CX, 0);
    chk("t6 credit10", int'(o_cr[0]), 10);
    chk("t6 chg", int'(o_cvld[0]), 1);
    #2 r = 1'b0;
    #1;
    rst_lits(0);
    rst_lits(1);
    @(posedge clk);
    #1 r = 1'b1;
    step(0, CX, 0);
    chk("t6 idle", int'(o_busy[0]), 0);
    chk("t6 credit0", int'(o_cr[0]), 0);

    // price 235, quarters only
    rst();
    for (int i = 0; i < 9; i++)
      step(1, CQ, 0);
    chk("t7 credit225", int'(o_cr[1]), 225);
    chk("t7 no vend", int'(o_vd[1]), 0);
    step(1, CQ, 0);
    chk("t7 credit250", int'(o_cr[1]), 250);
    chk("t7 vend", int'(o_vd[1]), 1);
    step(0, CX, 0);
    chk("t7 coin D", int'(o_cc[1]), 2);
    chk("t7 credit15", int'(o_cr[1]), 15);
    step(0, CX, 0);
    chk("t7 coin N", int'(o_cc[1]), 1);
    chk("t7 credit5", int'(o_cr[1]), 5);
    step(0, CX, 0);
    chk("t7 credit0", int'(o_cr[1]), 0);
    chk("t7 idle", int'(o_busy[1]), 0);
    step(0, CX, 0);
    step(0, CX, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vending_ctrl.md
# vending_ctrl

Parametrised coin-operated vending controller: accepts nickel, dime and quarter coins, accumulates credit up to a configurable price, pulses a vend strobe, then dispenses change one coin per cycle using a greedy largest-coin-first rule. Supports cancel/refund and rejects coins while busy. Sits between the coin-acceptor front end and the product/change actuators; all outputs are decoded from flops.

## Interface
- PRICE, 30: product price in cents; multiple of 5, range 5..235; violation is an elaboration error
- CREDIT_W, 8: credit register width; must satisfy 2^CREDIT_W > PRICE+20, else elaboration error
- clk  in  1  system clock, rising edge
- r  in  1  reset, asynchronous, active-low
- coin_valid  in  1  coin present this cycle (one-cycle pulse per coin)
- coin_sel  in  2  01 nickel=5, 10 dime=10, 11 quarter=25, 00 invalid (treated as reject)
- cancel  in  1  request refund of current credit
- credit  out  CREDIT_W  current credit in cents
- vend  out  1  one-cycle product-release strobe
- chg_valid  out  1  a change coin is being ejected this cycle
- chg_coin  out  2  coin being ejected (same encoding as coin_sel)
- coin_reject  out  1  one-cycle pulse: offered coin returned unaccepted
- busy  out  1  high in VEND and CHANGE

## Operation
- States: IDLE (credit=0), ACCUM (0<credit<PRICE), VEND, CHANGE.
- IDLE/ACCUM, coin_valid, valid coin, no cancel: credit<=credit+value; next state VEND if sum>=PRICE, else ACCUM.
- VEND: vend=1 for the single cycle; at the exit edge credit<=credit-PRICE; next CHANGE if remainder>0, else IDLE.
- CHANGE: chg_valid=1; chg_coin = quarter if credit>=25, else dime if >=10, else nickel; at each edge credit<=credit-coin value; leave to IDLE on the edge where credit reaches 0.
- cancel in ACCUM: go to CHANGE (refund entire credit, no vend). cancel in IDLE: ignored. cancel in VEND/CHANGE: ignored.
- cancel and coin_valid same cycle in ACCUM/IDLE: cancel wins, coin rejected.
- coin_valid with coin_sel=00, or in VEND/CHANGE: coin_reject pulses next cycle, credit unchanged.
- Arithmetic unsigned, CREDIT_W bits; max credit reached is PRICE+20, so no overflow by construction.

## Timing
- Reset (r=0, async): state IDLE, credit=0, vend=0, chg_valid=0, chg_coin=00, coin_reject=0, busy=0. Reset mid-VEND/CHANGE abandons the transaction; credit is lost.
- Coin sampled at edge N: credit updated visible after N; if price reached, vend high in cycle N..N+1 only.
- Change: first coin visible the cycle after the VEND cycle; one coin per cycle; no gaps.
- coin_reject: registered, high the cycle after the offending edge, for one cycle.
- busy registered alongside state; combinationally equal to (state==VEND || state==CHANGE).
- Coins are never lost silently: every coin_valid cycle yields either a credit increment or a coin_reject.

## Structure
- Package vending_pkg: state enum (IDLE, ACCUM, VEND, CHANGE), coin encodings (COIN_NONE, COIN_N, COIN_D, COIN_Q), value constants (5, 10, 25).
- Sub-module vend_change_sel: combinational greedy picker, credit in -> chg_coin and coin value out; reused by the refund path.
- Top module holds the state register, credit register and registered output strobes.

## Test plan
- PRICE=30: quarter then dime on consecutive cycles -> credit 25, 35; vend one cycle; one nickel ejected; credit 0; IDLE.
- PRICE=30: quarter, quarter -> vend; change dime, dime on two consecutive cycles; credit 50->20->10->0.
- Dime, dime, cancel -> no vend; change dime, dime; credit 0; coin_reject never asserted.
- Coin offered during VEND and during CHANGE, plus coin_sel=00 in IDLE -> coin_reject pulse each, credit trajectory unchanged.
- cancel and quarter same cycle with credit 10 -> coin_reject, refund one dime.
- Assert r low during CHANGE (credit 10) -> all outputs at reset values immediately, IDLE after release; PRICE=235, CREDIT_W=8 quarters-only run -> vend at 250, change quarter? no: 15 -> dime, nickel.
